// File: rtl/alu_operand_entry.sv
// Operand entry sequencer for the ALU bring-up board path: debounced pushbuttons
// capture operand A, operand B and the opcode from the switches, then hand them off with valid/ack.

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic key_raw,
  output logic press
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // NOTE: every register here reads the previous-cycle value of the others, so all
  // assignments are non-blocking; blocking ones would collapse the synchronizer stages.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Accept the new level; a fall from released (1) is a press.
        level <= sync2;
        cnt   <= '0;
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module alu_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  KEY,
  input  logic [17:0] SW,
  output logic [31:0] porta,
  output logic [31:0] portb,
  output logic [3:0]  aluop,
  output logic        op_valid,
  input  logic        op_ack,
  output logic [1:0]  entry_state
);
  typedef logic [31:0] word_t;
  typedef logic [3:0]  aluop_t;
  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_B  = 2'd1,
    GET_OP = 2'd2,
    ISSUE  = 2'd3
  } state_t;

  state_t state;
  logic   enter;
  logic   cancel;
  word_t  operand;
  aluop_t opcode;
  logic   unused_inputs;

  assign unused_inputs = ^{KEY[3:2], SW[17]};

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .CLK     (CLK),
    .RST     (RST),
    .key_raw (KEY[0]),
    .press   (enter)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
    .CLK     (CLK),
    .RST     (RST),
    .key_raw (KEY[1]),
    .press   (cancel)
  );

  assign operand = {{16{SW[16]}}, SW[15:0]};
  assign opcode  = SW[3:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= GET_A;
      porta    <= '0;
      portb    <= '0;
      aluop    <= '0;
      op_valid <= 1'b0;
    end else if (cancel) begin
      // Cancel outranks enter and ack; captured values are deliberately kept.
      state    <= GET_A;
      op_valid <= 1'b0;
    end else begin
      unique case (state)
        GET_A: if (enter) begin
          porta <= operand;
          state <= GET_B;
        end
        GET_B: if (enter) begin
          portb <= operand;
          state <= GET_OP;
        end
        GET_OP: if (enter) begin
          aluop    <= opcode;
          op_valid <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: if (op_ack) begin
          op_valid <= 1'b0;
          state    <= GET_A;
        end
        default: state <= GET_A;
      endcase
    end
  end

  assign entry_state = state;
endmodule

// File: tb/tb_alu_operand_entry.sv
// Bench for alu_operand_entry: directed scenarios plus random key/switch traffic,
// all compared every cycle against a window-based behavioural model.

module tb_alu_operand_entry;
  localparam int N    = 4;
  localparam int OFF  = 16;
  localparam int HMAX = 20000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  KEY;
  logic [17:0] SW;
  logic        op_ack;
  logic [31:0] porta;
  logic [31:0] portb;
  logic [3:0]  aluop;
  logic        op_valid;
  logic [1:0]  entry_state;

  int checks = 0;
  int errors = 0;

  alu_operand_entry #(.DEBOUNCE_CYCLES(N)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .KEY         (KEY),
    .SW          (SW),
    .porta       (porta),
    .portb       (portb),
    .aluop       (aluop),
    .op_valid    (op_valid),
    .op_ack      (op_ack),
    .entry_state (entry_state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext(input logic [17:0] s);
    logic signed [16:0] v;
    v = $signed(s[16:0]);
    return 32'(v);
  endfunction

  // Reference model: a key level flips once the last N synchronized samples all
  // disagree with it; samples are the KEY values seen two edges earlier.
  logic [1:0]  hist [0:HMAX-1];
  int          n = OFF;
  logic [1:0]  m_deb = 2'b11;
  logic [1:0]  m_pulse = 2'b00;
  int          m_state = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [3:0]  m_op = '0;
  bit          live = 1'b0;

  initial foreach (hist[i]) hist[i] = 2'b11;

  task automatic model_edge();
    logic       ent;
    logic       can;
    logic [1:0] np;
    bit         stable;
    ent = m_pulse[0];
    can = m_pulse[1];
    if (RST) begin
      m_state = 0; m_valid = 1'b0; m_a = '0; m_b = '0; m_op = '0;
      m_pulse = 2'b00; m_deb = 2'b11;
      hist[n] = 2'b11; hist[n-1] = 2'b11;
    end else begin
      if (can) begin
        m_state = 0; m_valid = 1'b0;
      end else begin
        case (m_state)
          0: if (ent) begin m_a = ext(SW); m_state = 1; end
          1: if (ent) begin m_b = ext(SW); m_state = 2; end
          2: if (ent) begin m_op = SW[3:0]; m_valid = 1'b1; m_state = 3; end
          default: if (op_ack) begin m_valid = 1'b0; m_state = 0; end
        endcase
      end
      hist[n] = KEY[1:0];
      np = 2'b00;
      for (int b = 0; b < 2; b++) begin
        stable = 1'b1;
        for (int k = n - N - 1; k <= n - 2; k++)
          if (hist[k][b] == m_deb[b]) stable = 1'b0;
        if (stable) begin
          np[b] = m_deb[b];
          m_deb[b] = ~m_deb[b];
        end
      end
      m_pulse = np;
    end
    n++;
  endtask

  always @(posedge CLK) begin
    model_edge();
    live = 1'b1;
  end

  always @(negedge CLK) begin
    if (live) begin
      check("m_porta", porta, m_a);
      check("m_portb", portb, m_b);
      check("m_aluop", 32'(aluop), 32'(m_op));
      check("m_valid", 32'(op_valid), 32'(m_valid));
      check("m_state", 32'(entry_state), 32'(m_state));
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge CLK);
  endtask

  task automatic press(input logic [3:0] mask);
    KEY = 4'hF & ~mask;
    cycles(N + 4);
    KEY = 4'hF;
    cycles(N + 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [31:0] a_keep;
    logic [31:0] b_keep;
    RST = 1'b1; KEY = 4'hF; SW = '0; op_ack = 1'b0;

    // Reset held 3 cycles with a key pulse inside it
    cycles(1); KEY = 4'hE; cycles(1); KEY = 4'hF; cycles(1);
    RST = 1'b0;
    check("rst_porta", porta, 32'h0);
    check("rst_valid", 32'(op_valid), 32'h0);
    check("rst_state", 32'(entry_state), 32'h0);
    cycles(N + 4);
    check("rst_nocap", 32'(entry_state), 32'h0);

    // Full entry and handshake
    SW = 18'h1_0005; press(4'b0001);
    check("full_porta", porta, 32'hFFFF0005);
    check("full_st1", 32'(entry_state), 32'h1);
    SW = 18'h0_0003; press(4'b0001);
    check("full_portb", portb, 32'h00000003);
    SW = 18'h0_0002; press(4'b0001);
    check("full_aluop", 32'(aluop), 32'h2);
    check("full_valid", 32'(op_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      SW = 18'($urandom);
      cycles(1);
      check("hold_valid", 32'(op_valid), 32'h1);
      check("hold_porta", porta, 32'hFFFF0005);
    end
    op_ack = 1'b1; cycles(1); op_ack = 1'b0;
    check("ack_valid", 32'(op_valid), 32'h0);
    check("ack_state", 32'(entry_state), 32'h0);

    // Glitch rejection: 3 low, 1 high, 3 low
    KEY = 4'hE; cycles(3); KEY = 4'hF; cycles(1); KEY = 4'hE; cycles(3); KEY = 4'hF;
    cycles(12);
    check("glitch_state", 32'(entry_state), 32'h0);

    // Clean press latency
    SW = 18'h0_1234;
    KEY = 4'hE; lat = 0;
    while (entry_state == 2'd0 && lat < 20) begin cycles(1); lat++; end
    check("press_latency", 32'(lat), 32'd7);
    cycles(10 - lat); KEY = 4'hF; cycles(N + 4);
    check("lat_porta", porta, 32'h00001234);
    check("lat_once", 32'(entry_state), 32'h1);

    // Cancel in GET_OP, then cancel in ISSUE
    SW = 18'h1_8001; press(4'b0001);
    a_keep = 32'h00001234; b_keep = 32'hFFFF8001;
    press(4'b0010);
    check("cancel_state", 32'(entry_state), 32'h0);
    check("cancel_porta", porta, a_keep);
    check("cancel_portb", portb, b_keep);
    press(4'b0001); press(4'b0001); SW = 18'h0_0007; press(4'b0001);
    check("issue_valid", 32'(op_valid), 32'h1);
    press(4'b0010);
    check("issue_cancel", 32'(op_valid), 32'h0);

    // Simultaneous enter and cancel in GET_B
    SW = 18'h0_0042; press(4'b0001);
    b_keep = portb;
    SW = 18'h0_0099; press(4'b0011);
    check("simul_state", 32'(entry_state), 32'h0);
    check("simul_portb", portb, b_keep);

    // Reset in ISSUE, then a normal capture
    press(4'b0001); press(4'b0001); press(4'b0001);
    check("pre_rst_valid", 32'(op_valid), 32'h1);
    RST = 1'b1; cycles(1); RST = 1'b0;
    check("mid_rst_valid", 32'(op_valid), 32'h0);
    check("mid_rst_porta", porta, 32'h0);
    check("mid_rst_aluop", 32'(aluop), 32'h0);
    SW = 18'h1_FFFE; press(4'b0001);
    check("post_rst_porta", porta, 32'hFFFFFFFE);

    // Random traffic against the model
    for (int s = 0; s < 400; s++) begin
      KEY = {2'b11, ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1, 1'($urandom_range(0, 1))};
      for (int c = 0; c < int'($urandom_range(1, 10)); c++) begin
        SW = 18'($urandom);
        op_ack = ($urandom_range(0, 3) == 0);
        RST = ($urandom_range(0, 300) == 0);
        cycles(1);
      end
    end
    RST = 1'b0; KEY = 4'hF; op_ack = 1'b0;
    cycles(N + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
